uart_time_cmd: RTL and testbench
================================

// Module: uart_time_cmd
// PURPOSE
//  Parses ASCII set-time frames from uart_rx (data/rx_done) and produces a validated date/time load for watch_time.
//  Sits between the UART receiver and the time-keeping counter in the digital clock.
//  Frame: 'T' Y Y Y Y M M D D h h m m s s CR(0x0D). Decimal digits only, 16 bytes total.
//  Replies to uart_tx with one byte: 'K' (0x4B) on success, 'E' (0x45) on error.
// PARAMETERS
//  TIMEOUT_CLKS  260400  max clk cycles between bytes inside a frame (~5 byte times at 9600 baud, 50 MHz)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, synchronous, active-low
//  rx_data    in   8   received byte, valid when rx_done=1
//  rx_done    in   1   one-cycle pulse per received byte
//  tx_busy    in   1   uart_tx busy flag
//  year_o     out  14  binary year, 0..9999
//  month_o    out  8   BCD month, 01..12
//  day_o      out  8   BCD day
//  hour_o     out  8   BCD hour, 00..23
//  min_o      out  8   BCD minute, 00..59
//  sec_o      out  8   BCD second, 00..59
//  set_stb    out  1   one-cycle load strobe; fields valid on this cycle and held until the next set_stb
//  err_stb    out  1   one-cycle error strobe
//  err_code   out  2   0=none 1=format 2=range 3=timeout; held until the next frame ends
//  tx_data    out  8   response byte
//  tx_req     out  1   one-cycle send request
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0 at clk edge): all outputs 0, FSM=IDLE, counters cleared. Aborts any frame in progress; no strobe, no reply.
//  FSM states: IDLE, DIGITS, WAIT_CR, CHECK, COMMIT, RESP.
//  IDLE: on rx_done with 'T' go to DIGITS, clear digit_cnt, year accumulator and timer. All other bytes are ignored silently.
//  DIGITS: on each rx_done with 0x30..0x39, store the digit and increment digit_cnt.
//   - Year digits 0..3 accumulate as acc = acc*10 + d, computed as (acc<<3)+(acc<<1)+d, 14 bits, no overflow possible.
//   - Digits 4..13 are packed into the BCD fields in frame order.
//   - When the 14th digit is stored, go to WAIT_CR.
//   - Any non-digit byte, including 'T' and CR, is a format error.
//  WAIT_CR: 0x0D goes to CHECK. Any other byte is a format error.
//  CHECK (1 cycle): range checks.
//   - month 01..12; hour <= 23; min <= 59; sec <= 59.
//   - day from 01 to max_day(month, leap).
//   - max_day: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb = 29 if leap, else 28.
//   - Leap: year%4==0 && (year%100!=0 || year%400==0), using the binary year.
//   - Any BCD nibble >9 cannot occur (digits are pre-filtered).
//   - Pass goes to COMMIT. Fail is a range error.
//  COMMIT (1 cycle): drive set_stb=1 and update the output fields in the same cycle; err_code=0; go to RESP with 'K'.
//  Latency: CR rx_done at cycle N gives CHECK at N+1 and set_stb at N+2.
//  Error path (any state): err_stb=1 for one cycle, err_code set, output fields unchanged, go to RESP with 'E'.
//  Timeout: in DIGITS/WAIT_CR the timer resets on every rx_done. Reaching TIMEOUT_CLKS-1 is a timeout error.
//  RESP: wait while tx_busy=1. The first cycle with tx_busy=0 drives tx_req=1 for one cycle, then go to IDLE.
//   - rx_done during CHECK/COMMIT/RESP is dropped.
//  Simultaneous events:
//   - rx_done and timer terminal count in the same cycle: the byte wins; the timer resets.
//   - A new 'T' while busy outside DIGITS/WAIT_CR is dropped.
// STRUCTURE
//  Shared package (clock_pkg): ASCII constants (CH_T, CH_CR, CH_K, CH_E, CH_0, CH_9), ERR_* codes, FSM state encoding.
//  Sub-module date_range_check: combinational; inputs year, month, day, hour, min, sec; output ok.
//   - Contains the leap-year and max-day logic.
//  Top: FSM, digit counter, year accumulator, BCD shift-in registers, timeout counter, response handshake.
// TESTING
//  1. "T20240229235959\r" with tx_busy=0 -> set_stb at CR+2; year_o=2024, month_o=8'h02, day_o=8'h29, hour/min/sec=23/59/59 BCD; tx 'K'.
//  2. "T20230229000000\r" -> err_stb, err_code=2, fields unchanged, tx 'E'; repeat with 2000 (ok) and 1900 (err 2).
//  3. "T2024A1..." -> err_code=1 at the 'A' byte, tx 'E'; a frame of 14 digits followed by 'X' -> err_code=1.
//  4. 'T' + 5 digits then silence -> err_code=3 exactly TIMEOUT_CLKS-1 cycles after the last rx_done.
//     Use a small TIMEOUT_CLKS (e.g. 50) in the bench.
//  5. Stray bytes "xyz\r" in IDLE -> no strobes, no tx_req, busy stays 0.
//  6. tx_busy held high for 100 cycles at the end of a valid frame -> tx_req asserts on the first cycle after tx_busy falls.
//     rst=0 mid-frame -> all outputs 0 next cycle; no strobe, no reply.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the digital clock: ASCII bytes, error codes and the
// set-time command FSM encoding.
package clock_pkg;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FORMAT  = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StDigits,
    StWaitCr,
    StCheck,
    StCommit,
    StResp
  } state_e;

endpackage

// File: rtl/date_range_check.sv
// Combinational validity check of a BCD date/time against a binary year,
// including the Gregorian leap-year rule.
module date_range_check (
  input  logic [13:0] year,
  input  logic [7:0]  month,
  input  logic [7:0]  day,
  input  logic [7:0]  hour,
  input  logic [7:0]  min,
  input  logic [7:0]  sec,
  output logic        ok
);

  logic       leap;
  logic [7:0] max_day;

  // Fields hold decimal digits only, so BCD compares order like binary ones.
  always_comb begin
    leap = (year % 14'd4 == 14'd0) &&
           ((year % 14'd100 != 14'd0) || (year % 14'd400 == 14'd0));
    case (month)
      8'h02:                      max_day = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
      default:                    max_day = 8'h31;
    endcase
    ok = (month >= 8'h01) && (month <= 8'h12) &&
         (day >= 8'h01) && (day <= max_day) &&
         (hour <= 8'h23) && (min <= 8'h59) && (sec <= 8'h59);
  end

endmodule

// File: rtl/uart_time_cmd.sv
// Parses "TYYYYMMDDhhmmss<CR>" frames from the UART receiver, validates them
// and produces a one-cycle time load plus a 'K'/'E' reply byte.
module uart_time_cmd
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 260400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        tx_busy,
  output logic [13:0] year_o,
  output logic [7:0]  month_o,
  output logic [7:0]  day_o,
  output logic [7:0]  hour_o,
  output logic [7:0]  min_o,
  output logic [7:0]  sec_o,
  output logic        set_stb,
  output logic        err_stb,
  output logic [1:0]  err_code,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  output logic        busy
);

  localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT_CLKS - 1);

  state_e        state_q, state_d;
  logic [3:0]    digit_cnt_q, digit_cnt_d;
  logic [13:0]   acc_q, acc_d;
  logic [39:0]   bcd_q, bcd_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [1:0]    err_code_q, err_code_d, err_now;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [13:0]   year_q;
  logic [7:0]    month_q, day_q, hour_q, min_q, sec_q;
  logic          is_digit, load, range_ok;

  date_range_check u_check (
    .year  (acc_q),
    .month (bcd_q[39:32]),
    .day   (bcd_q[31:24]),
    .hour  (bcd_q[23:16]),
    .min   (bcd_q[15:8]),
    .sec   (bcd_q[7:0]),
    .ok    (range_ok)
  );

  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    acc_d       = acc_q;
    bcd_d       = bcd_q;
    timer_d     = timer_q;
    err_code_d  = err_code_q;
    tx_data_d   = tx_data_q;
    err_now     = ERR_NONE;
    load        = 1'b0;
    set_stb     = 1'b0;
    tx_req      = 1'b0;
    is_digit    = (rx_data >= CH_0) && (rx_data <= CH_9);
    timer_inc   = timer_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (rx_done && (rx_data == CH_T)) begin
          state_d     = StDigits;
          digit_cnt_d = '0;
          acc_d       = '0;
          timer_d     = '0;
        end
      end
      StDigits: begin
        if (rx_done) begin
          timer_d = '0;
          if (is_digit) begin
            digit_cnt_d = digit_cnt_q + 4'd1;
            if (digit_cnt_q < 4'd4) begin
              acc_d = (acc_q << 3) + (acc_q << 1) + {10'd0, rx_data[3:0]};
            end else begin
              bcd_d = {bcd_q[35:0], rx_data[3:0]};
            end
            if (digit_cnt_q == 4'd13) state_d = StWaitCr;
          end else begin
            err_now = ERR_FORMAT;
          end
        end else if (timer_inc == TIMER_TERM) begin
          err_now = ERR_TIMEOUT;
        end else begin
          timer_d = timer_inc;
        end
      end
      StWaitCr: begin
        if (rx_done) begin
          timer_d = '0;
          if (rx_data == CH_CR) state_d = StCheck;
          else                  err_now = ERR_FORMAT;
        end else if (timer_inc == TIMER_TERM) begin
          err_now = ERR_TIMEOUT;
        end else begin
          timer_d = timer_inc;
        end
      end
      StCheck: begin
        if (range_ok) begin
          load       = 1'b1;
          err_code_d = ERR_NONE;
          tx_data_d  = CH_K;
          state_d    = StCommit;
        end else begin
          err_now = ERR_RANGE;
        end
      end
      StCommit: begin
        set_stb = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (!tx_busy) begin
          tx_req  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_now != ERR_NONE) begin
      err_code_d = err_now;
      tx_data_d  = CH_E;
      state_d    = StResp;
    end
    err_stb = (err_now != ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      digit_cnt_q <= '0;
      acc_q       <= '0;
      bcd_q       <= '0;
      timer_q     <= '0;
      err_code_q  <= ERR_NONE;
      tx_data_q   <= '0;
      year_q      <= '0;
      month_q     <= '0;
      day_q       <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      acc_q       <= acc_d;
      bcd_q       <= bcd_d;
      timer_q     <= timer_d;
      err_code_q  <= err_code_d;
      tx_data_q   <= tx_data_d;
      // Loaded on the CHECK->COMMIT edge so the fields change with set_stb.
      if (load) begin
        year_q  <= acc_q;
        month_q <= bcd_q[39:32];
        day_q   <= bcd_q[31:24];
        hour_q  <= bcd_q[23:16];
        min_q   <= bcd_q[15:8];
        sec_q   <= bcd_q[7:0];
      end
    end
  end

  assign year_o   = year_q;
  assign month_o  = month_q;
  assign day_o    = day_q;
  assign hour_o   = hour_q;
  assign min_o    = min_q;
  assign sec_o    = sec_q;
  assign err_code = err_stb ? err_now : err_code_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_time_cmd.sv
// Randomised frame-level bench for uart_time_cmd: a byte-list model predicts
// each frame's outcome and event cycles, and a per-cycle monitor compares.
module tb_uart_time_cmd;
  import clock_pkg::*;

  localparam int unsigned T = 50;

  typedef byte unsigned bq_t[$];
  typedef struct {
    int kind;  // 0 ok, 1 format, 2 range, 3 timeout
    int idx;
    int year;
    int mo;
    int dy;
    int hh;
    int mi;
    int ss;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_busy = 1'b0;
  logic [13:0] year_o;
  logic [7:0]  month_o, day_o, hour_o, min_o, sec_o, tx_data;
  logic        set_stb, err_stb, tx_req, busy;
  logic [1:0]  err_code;

  uart_time_cmd #(.TIMEOUT_CLKS(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_busy  (tx_busy),
    .year_o   (year_o),
    .month_o  (month_o),
    .day_o    (day_o),
    .hour_o   (hour_o),
    .min_o    (min_o),
    .sec_o    (sec_o),
    .set_stb  (set_stb),
    .err_stb  (err_stb),
    .err_code (err_code),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectations written by the driver
  int frame_id = 0, busy_start = -1, set_c = -1, err_c = -1, resp_c = -1;
  int skip_c = -1, rst_c = -1, last_c = -1, rel_c = -1;
  bit chk_en = 1'b0;
  logic [1:0] e_code = 2'd0;
  logic [7:0] e_tx = 8'h00;
  int p_year = 0;
  logic [7:0] p_mo = 0, p_dy = 0, p_hh = 0, p_mi = 0, p_ss = 0;

  // Observed state kept by the monitor
  int done_id = 0, done_c = -1, set_seen_c = -1, err_seen_c = -1;
  int m_year = 0;
  logic [7:0] m_mo = 0, m_dy = 0, m_hh = 0, m_mi = 0, m_ss = 0;
  logic [1:0] m_code = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int max_day(input int mo, input int y);
    bit leap;
    leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    if (mo == 2) return leap ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic res_t model(input bq_t f);
    res_t r;
    int d[16];
    r = '{default: 0};
    for (int i = 0; i < 16; i++) d[i] = 0;
    for (int i = 1; i < f.size(); i++) begin
      if (i <= 14 && (f[i] < 48 || f[i] > 57)) begin r.kind = 1; r.idx = i; return r; end
      if (i == 15 && f[i] != 13) begin r.kind = 1; r.idx = 15; return r; end
      if (i <= 14) d[i] = int'(f[i]) - 48;
    end
    if (f.size() < 16) begin r.kind = 3; r.idx = f.size() - 1; return r; end
    r.year = d[1] * 1000 + d[2] * 100 + d[3] * 10 + d[4];
    r.mo = d[5] * 10 + d[6];
    r.dy = d[7] * 10 + d[8];
    r.hh = d[9] * 10 + d[10];
    r.mi = d[11] * 10 + d[12];
    r.ss = d[13] * 10 + d[14];
    r.kind = (r.mo >= 1 && r.mo <= 12 && r.dy >= 1 && r.dy <= max_day(r.mo, r.year) &&
              r.hh <= 23 && r.mi <= 59 && r.ss <= 59) ? 0 : 2;
    return r;
  endfunction

  function automatic bq_t from_str(input string s, input bit cr);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    if (cr) q.push_back(8'h0D);
    return q;
  endfunction

  function automatic bq_t mk(input int y, mo, d, h, mi, s);
    bq_t q;
    int ds[14];
    ds = '{y / 1000, (y / 100) % 10, (y / 10) % 10, y % 10, mo / 10, mo % 10, d / 10, d % 10,
           h / 10, h % 10, mi / 10, mi % 10, s / 10, s % 10};
    q.push_back(CH_T);
    for (int i = 0; i < 14; i++) q.push_back(8'(48 + ds[i]));
    q.push_back(8'h0D);
    return q;
  endfunction

  // Monitor: every cycle, compare all outputs against the expectation set
  always @(negedge clk) begin
    bit in_resp, exp_req, exp_busy;
    if (chk_en && cyc != skip_c) begin
      if (cyc == rst_c) begin
        m_year = 0; m_mo = 0; m_dy = 0; m_hh = 0; m_mi = 0; m_ss = 0; m_code = 0;
      end
      if (cyc == set_c) begin
        m_year = p_year; m_mo = p_mo; m_dy = p_dy; m_hh = p_hh; m_mi = p_mi; m_ss = p_ss;
        m_code = ERR_NONE;
      end
      if (cyc == err_c) m_code = e_code;
      in_resp  = (resp_c >= 0) && (cyc >= resp_c) && (done_id != frame_id);
      exp_req  = in_resp && !tx_busy;
      exp_busy = (busy_start >= 0) && (cyc >= busy_start) && (done_id != frame_id);
      check("set_stb", 32'(set_stb), 32'(cyc == set_c));
      check("err_stb", 32'(err_stb), 32'(cyc == err_c));
      check("err_code", 32'(err_code), 32'(m_code));
      check("year_o", 32'(year_o), 32'(m_year));
      check("month_o", 32'(month_o), 32'(m_mo));
      check("day_o", 32'(day_o), 32'(m_dy));
      check("hour_o", 32'(hour_o), 32'(m_hh));
      check("min_o", 32'(min_o), 32'(m_mi));
      check("sec_o", 32'(sec_o), 32'(m_ss));
      check("busy", 32'(busy), 32'(exp_busy));
      check("tx_req", 32'(tx_req), 32'(exp_req));
      if (set_stb) set_seen_c = cyc;
      if (err_stb) err_seen_c = cyc;
      if (exp_req && tx_req) begin
        check("tx_data", 32'(tx_data), 32'(e_tx));
        done_id = frame_id;
        done_c  = cyc;
      end
    end
  end

  task automatic send_frame(input bq_t f, input int hold);
    res_t r;
    int n, c;
    r = model(f);
    frame_id++;
    busy_start = -1; set_c = -1; err_c = -1; resp_c = -1;
    n = (r.kind == 1) ? r.idx + 1 : f.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      c = cyc;
      last_c = c;
      if (i == 0) busy_start = c + 1;
      if (i == n - 1) begin
        case (r.kind)
          0: begin
            p_year = r.year; p_mo = bcd(r.mo); p_dy = bcd(r.dy);
            p_hh = bcd(r.hh); p_mi = bcd(r.mi); p_ss = bcd(r.ss);
            set_c = c + 2; resp_c = c + 3; e_tx = CH_K;
          end
          1: begin err_c = c; e_code = ERR_FORMAT; resp_c = c + 1; e_tx = CH_E; end
          2: begin err_c = c + 1; e_code = ERR_RANGE; resp_c = c + 2; e_tx = CH_E; end
          default: begin
            err_c = c + T - 1; e_code = ERR_TIMEOUT; resp_c = c + T; e_tx = CH_E;
          end
        endcase
        if (hold > 0) tx_busy = 1'b1;
      end
      rx_data = f[i];
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
    end
    if (hold > 0) begin
      for (int k = 1; k < hold; k++) begin
        // A 'T' arriving while the reply is pending must be dropped
        if (k == 6 && hold >= 20) begin rx_data = CH_T; rx_done = 1'b1; end
        tick();
        rx_done = 1'b0;
      end
      tx_busy = 1'b0;
      rel_c = cyc;
    end
    for (int k = 0; k < T + 400 && done_id != frame_id; k++) tick();
    check("resp_done", 32'(done_id == frame_id), 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    bq_t q;
    int y, mo, kind, p, nd;
    byte unsigned b;

    repeat (3) tick();
    rst = 1'b1;
    chk_en = 1'b1;
    check("rst_year", 32'(year_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    tick();

    // Leap day, latest time of day
    send_frame(from_str("T20240229235959", 1'b1), 0);
    check("t1_latency", 32'(set_seen_c - last_c), 32'd2);
    check("t1_year", 32'(year_o), 32'd2024);
    check("t1_month", 32'(month_o), 32'h02);
    check("t1_day", 32'(day_o), 32'h29);
    check("t1_hms", {8'h0, hour_o, min_o, sec_o}, 32'h235959);
    check("t1_tx", 32'(tx_data), 32'h4B);

    send_frame(from_str("T20230229000000", 1'b1), 0);
    check("t2_code", 32'(err_code), 32'd2);
    check("t2_year_held", 32'(year_o), 32'd2024);
    check("t2_tx", 32'(tx_data), 32'h45);
    send_frame(from_str("T20000229000000", 1'b1), 0);
    check("t2_y2000", 32'(year_o), 32'd2000);
    send_frame(from_str("T19000229000000", 1'b1), 0);
    check("t2_y1900_code", 32'(err_code), 32'd2);
    check("t2_y1900_held", 32'(year_o), 32'd2000);

    send_frame(from_str("T2024A1", 1'b0), 0);
    check("t3_code_a", 32'(err_code), 32'd1);
    send_frame(from_str("T20240101000000X", 1'b0), 0);
    check("t3_code_x", 32'(err_code), 32'd1);

    send_frame(from_str("T20241", 1'b0), 0);
    check("t4_code", 32'(err_code), 32'd3);
    check("t4_delay", 32'(err_seen_c - last_c), 32'(T - 1));

    // Stray bytes in idle must be ignored
    q = from_str("xyz", 1'b1);
    foreach (q[i]) begin
      rx_data = q[i]; rx_done = 1'b1; tick(); rx_done = 1'b0; tick();
    end
    check("t5_busy", 32'(busy), 32'd0);

    send_frame(from_str("T20991231120000", 1'b1), 100);
    check("t6_req_at_release", 32'(done_c), 32'(rel_c));
    check("t6_day", 32'(day_o), 32'h31);

    // Reset in the middle of a frame
    q = from_str("T202406", 1'b0);
    frame_id++;
    set_c = -1; err_c = -1; resp_c = -1;
    foreach (q[i]) begin
      if (i == 0) busy_start = cyc + 1;
      rx_data = q[i]; rx_done = 1'b1; tick(); rx_done = 1'b0;
    end
    tick();
    rst = 1'b0; skip_c = cyc; rst_c = cyc + 1; busy_start = -1;
    tick();
    rst = 1'b1;
    check("rst_mid_year", 32'(year_o), 32'd0);
    check("rst_mid_tx_data", 32'(tx_data), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (T + 20) tick();

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      y = $urandom_range(0, 9999);
      mo = $urandom_range(1, 12);
      q = mk(y, mo, $urandom_range(1, max_day(mo, y)), $urandom_range(0, 23),
             $urandom_range(0, 59), $urandom_range(0, 59));
      if (kind == 1) begin
        for (int i = 1; i <= 14; i++) q[i] = 8'(48 + $urandom_range(0, 9));
      end else if (kind == 2) begin
        p = $urandom_range(1, 15);
        do b = 8'($urandom_range(0, 255));
        while ((p <= 14 && b >= 48 && b <= 57) || (p == 15 && b == 13));
        q[p] = b;
      end else if (kind == 3) begin
        nd = $urandom_range(0, 14);
        while (q.size() > nd + 1) void'(q.pop_back());
      end
      send_frame(q, (kind == 3) ? 0 : $urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
